multicycle_ctrl: RTL and testbench

- Control FSM that sequences the RV32I datapath over several cycles: FETCH, DECODE, EXEC, MEM, WB.
- Shares one memory port between instruction fetch and load/store using a req/ready handshake.
- Drives the datapath control inputs: memtoreg, pcsrc, alusrc, regwrite, alu_operation.
- Also drives register enables: ir_we, pc_we, mdr_we.

---
 rtl/multicycle_ctrl_pkg.sv | 65 ++++++
 rtl/multicycle_ctrl_alu_decoder.sv | 44 ++++
 rtl/multicycle_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control unit.
// Holds the RV32I major opcodes, the ALU operation codes shared with the ALU,
// the 3-bit FSM state encoding and the instruction-class type, plus small
// helpers for opcode classification and memory-state detection.
package multicycle_ctrl_pkg;

  // RV32I major opcodes handled by this controller
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // ALU operation codes
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEMRD  = 3'd4,
    ST_MEMWR  = 3'd5,
    ST_WB     = 3'd6,
    ST_TRAP   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CL_NONE   = 3'd0,
    CL_R      = 3'd1,
    CL_I      = 3'd2,
    CL_LOAD   = 3'd3,
    CL_STORE  = 3'd4,
    CL_BRANCH = 3'd5
  } iclass_e;

  // Map a major opcode onto an instruction class; unknown opcodes give CL_NONE
  function automatic iclass_e classify(input logic [6:0] opc);
    iclass_e cls;
    case (opc)
      OPC_R:      cls = CL_R;
      OPC_I:      cls = CL_I;
      OPC_LOAD:   cls = CL_LOAD;
      OPC_STORE:  cls = CL_STORE;
      OPC_BRANCH: cls = CL_BRANCH;
      default:    cls = CL_NONE;
    endcase
    return cls;
  endfunction

  // States that own the shared memory port
  function automatic logic is_mem_state(input state_e st);
    return (st == ST_FETCH) || (st == ST_MEMRD) || (st == ST_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU operation decoder.
// Ports:
//   cls_i      - instruction class (iclass_e encoding)
//   funct3_i   - instruction[14:12]
//   funct7_5_i - instruction[30]
//   alu_op_o   - 4-bit ALU operation code
module multicycle_ctrl_alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [2:0] cls_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output logic [3:0] alu_op_o
);

  // Immediate forms never subtract: funct7_5 there is immediate bits, not an op modifier
  logic sub_sel_s;
  assign sub_sel_s = (cls_i == CL_R) && funct7_5_i;

  // Select the ALU operation from class and function fields
  always_comb begin
    alu_op_o = ALU_AND;
    case (cls_i)
      CL_LOAD, CL_STORE: alu_op_o = ALU_ADD;
      CL_BRANCH:         alu_op_o = ALU_SUB;
      CL_R, CL_I: begin
        case (funct3_i)
          3'b000:  alu_op_o = sub_sel_s ? ALU_SUB : ALU_ADD;
          3'b001:  alu_op_o = ALU_SLL;
          3'b010:  alu_op_o = ALU_SLT;
          3'b011:  alu_op_o = ALU_SLTU;
          3'b100:  alu_op_o = ALU_XOR;
          // SRAI/SRA both use funct7_5 as the arithmetic-shift selector
          3'b101:  alu_op_o = funct7_5_i ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op_o = ALU_OR;
          3'b111:  alu_op_o = ALU_AND;
          default: alu_op_o = ALU_AND;
        endcase
      end
      default: alu_op_o = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: IDLE -> FETCH -> DECODE -> EXEC -> (MEMRD|MEMWR) -> WB.
// One memory port is shared by fetch and load/store with a req/ready handshake.
// Configuration macro: MEM_TIMEOUT_EN -- when defined, a wait counter traps the
// FSM after TIMEOUT_CYCLES consecutive cycles of mem_req without mem_ready.
// Ports:
//   clk, reset (async, active-high)
//   opcode, funct3, funct7_5     - fields of the instruction register
//   branch_taken                 - branch comparator result
//   mem_ready                    - memory completes the request this cycle
//   mem_req, mem_we, iord        - memory port control
//   ir_we, mdr_we, pc_we         - register load enables (pulses qualified by mem_ready)
//   pcsrc, alusrc, memtoreg, regwrite, alu_operation - datapath control
//   trap                         - sticky fault indicator
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       mdr_we,
  output logic       pc_we,
  output logic       pcsrc,
  output logic       alusrc,
  output logic       memtoreg,
  output logic       regwrite,
  output logic [3:0] alu_operation,
  output logic       trap
);

  state_e     state_q, state_d;
  iclass_e    class_q, class_d;
  logic [3:0] aluop_q, aluop_d;
  logic       alusrc_q, alusrc_d;

  // Registered Moore outputs, computed from the next state
  logic mem_req_q, mem_we_q, iord_q, regwrite_q, memtoreg_q, trap_q;
  logic pcwe_q;      // unconditional pc update (WB, branch EXEC)
  logic br_exec_q;   // in EXEC of a branch

  iclass_e    cls_s;
  logic [3:0] dec_op_s;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 32'd255) ?
                                  $clog2(TIMEOUT_CYCLES + 32'd1) : 32'd8;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d, wait_inc_s;
`endif

  assign cls_s = classify(opcode);

  multicycle_ctrl_alu_decoder u_alu_dec (
    .cls_i      (cls_s),
    .funct3_i   (funct3),
    .funct7_5_i (funct7_5),
    .alu_op_o   (dec_op_s)
  );

  // Next-state, decode-field and wait-counter logic
  always_comb begin
    state_d  = state_q;
    class_d  = class_q;
    aluop_d  = aluop_q;
    alusrc_d = alusrc_q;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready) state_d = ST_DECODE;
        else           state_d = ST_FETCH;
      end
      ST_DECODE: begin
        class_d  = cls_s;
        aluop_d  = dec_op_s;
        alusrc_d = (cls_s == CL_I) || (cls_s == CL_LOAD) || (cls_s == CL_STORE);
        if (cls_s == CL_NONE) state_d = ST_TRAP;
        else                  state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (class_q)
          CL_R, CL_I: state_d = ST_WB;
          CL_LOAD:    state_d = ST_MEMRD;
          CL_STORE:   state_d = ST_MEMWR;
          CL_BRANCH:  state_d = ST_FETCH;
          default:    state_d = ST_TRAP;
        endcase
      end
      ST_MEMRD: begin
        if (mem_ready) state_d = ST_WB;
        else           state_d = ST_MEMRD;
      end
      ST_MEMWR: begin
        if (mem_ready) state_d = ST_FETCH;
        else           state_d = ST_MEMWR;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_TRAP;
    endcase

`ifdef MEM_TIMEOUT_EN
    // Counter is zero whenever a wait is not in progress, so every entry starts from 0
    wait_inc_s = wait_cnt_q + 1'b1;
    if (is_mem_state(state_q) && !mem_ready) begin
      wait_cnt_d = wait_inc_s;
      if (wait_inc_s == CNT_W'(TIMEOUT_CYCLES)) state_d = ST_TRAP;
      else                                     state_d = state_d;
    end else begin
      wait_cnt_d = '0;
    end
`endif

    // Decode fields live from EXEC until the next fetch; TRAP shows all zeros
    if ((state_d == ST_FETCH) || (state_d == ST_TRAP)) begin
      class_d  = CL_NONE;
      aluop_d  = ALU_AND;
      alusrc_d = 1'b0;
    end else begin
      class_d  = class_d;
    end
  end

  // FSM state, decode fields and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      class_q    <= CL_NONE;
      aluop_q    <= ALU_AND;
      alusrc_q   <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      iord_q     <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      trap_q     <= 1'b0;
      pcwe_q     <= 1'b0;
      br_exec_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      class_q    <= class_d;
      aluop_q    <= aluop_d;
      alusrc_q   <= alusrc_d;
      mem_req_q  <= is_mem_state(state_d);
      mem_we_q   <= (state_d == ST_MEMWR);
      iord_q     <= (state_d == ST_MEMRD) || (state_d == ST_MEMWR);
      regwrite_q <= (state_d == ST_WB);
      memtoreg_q <= (state_d == ST_WB) && (class_d == CL_LOAD);
      trap_q     <= (state_d == ST_TRAP);
      pcwe_q     <= (state_d == ST_WB) || ((state_d == ST_EXEC) && (class_d == CL_BRANCH));
      br_exec_q  <= (state_d == ST_EXEC) && (class_d == CL_BRANCH);
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign iord          = iord_q;
  assign regwrite      = regwrite_q;
  assign memtoreg      = memtoreg_q;
  assign trap          = trap_q;
  assign alusrc        = alusrc_q;
  assign alu_operation = aluop_q;

  // Load enables fire in the very cycle memory completes
  assign ir_we  = (state_q == ST_FETCH) && mem_ready;
  assign mdr_we = (state_q == ST_MEMRD) && mem_ready;
  assign pc_we  = pcwe_q || ((state_q == ST_MEMWR) && mem_ready);
  // Only a branch in EXEC can select the branch target
  assign pcsrc  = br_exec_q && branch_taken;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl.
// Inputs are driven just after the falling edge, outputs are checked 1 ns later.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       branch_taken;
  logic       mem_ready;
  logic       mem_req, mem_we, iord, ir_we, mdr_we, pc_we, pcsrc;
  logic       alusrc, memtoreg, regwrite, trap;
  logic [3:0] alu_operation;
  logic [14:0] outs_s;

  int n_cmp = 0;
  int n_err = 0;
  int mdr_pulses;

  logic [14:0] alu_vec [0:14];

  multicycle_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7_5      (funct7_5),
    .branch_taken  (branch_taken),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .iord          (iord),
    .ir_we         (ir_we),
    .mdr_we        (mdr_we),
    .pc_we         (pc_we),
    .pcsrc         (pcsrc),
    .alusrc        (alusrc),
    .memtoreg      (memtoreg),
    .regwrite      (regwrite),
    .alu_operation (alu_operation),
    .trap          (trap)
  );

  assign outs_s = {mem_req, mem_we, iord, ir_we, mdr_we, pc_we, pcsrc,
                   alusrc, memtoreg, regwrite, alu_operation, trap};

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, drive this cycle's inputs, let outputs settle
  task automatic cyc(input logic rdy, input logic bt);
    @(negedge clk);
    mem_ready    = rdy;
    branch_taken = bt;
    #1;
  endtask

  task automatic set_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7);
    opcode   = opc;
    funct3   = f3;
    funct7_5 = f7;
  endtask

  // Reset and leave the DUT in IDLE (cycle 0); the next cyc() is FETCH
  task automatic do_reset();
    reset        = 1'b1;
    mem_ready    = 1'b1;
    branch_taken = 1'b1;
    @(negedge clk);
    #1;
    check_val("rst_outs", {17'd0, outs_s}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("idle_outs", {17'd0, outs_s}, 32'd0);
  endtask

  // Bound on total run time
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  // Main directed sequence
  initial begin
    // {opcode, funct3, funct7_5, expected alu_operation}
    alu_vec[0]  = {7'b0110011, 3'b000, 1'b0, 4'b0010};
    alu_vec[1]  = {7'b0110011, 3'b000, 1'b1, 4'b0110};
    alu_vec[2]  = {7'b0110011, 3'b001, 1'b0, 4'b0100};
    alu_vec[3]  = {7'b0110011, 3'b010, 1'b0, 4'b1000};
    alu_vec[4]  = {7'b0110011, 3'b011, 1'b0, 4'b1001};
    alu_vec[5]  = {7'b0110011, 3'b100, 1'b0, 4'b0011};
    alu_vec[6]  = {7'b0110011, 3'b101, 1'b0, 4'b0101};
    alu_vec[7]  = {7'b0110011, 3'b101, 1'b1, 4'b0111};
    alu_vec[8]  = {7'b0110011, 3'b110, 1'b0, 4'b0001};
    alu_vec[9]  = {7'b0110011, 3'b111, 1'b0, 4'b0000};
    alu_vec[10] = {7'b0010011, 3'b101, 1'b1, 4'b0111};
    alu_vec[11] = {7'b0010011, 3'b000, 1'b1, 4'b0010};
    alu_vec[12] = {7'b0010011, 3'b010, 1'b0, 4'b1000};
    alu_vec[13] = {7'b0100011, 3'b010, 1'b0, 4'b0010};
    alu_vec[14] = {7'b1100011, 3'b000, 1'b0, 4'b0110};

    reset = 1'b1;
    set_instr(7'b0110011, 3'b000, 1'b0);
    mem_ready = 1'b0;
    branch_taken = 1'b0;

    // add x3,x1,x2 (0x002081B3), zero-wait memory
    do_reset();
    set_instr(7'b0110011, 3'b000, 1'b0);
    cyc(1'b1, 1'b0);
    check_val("add_c1_irwe", {31'd0, ir_we}, 32'd1);
    check_val("add_c1_req", {29'd0, mem_req, iord, mem_we}, 32'h4);
    cyc(1'b1, 1'b0);
    check_val("add_c2_decode", {17'd0, outs_s}, 32'd0);
    cyc(1'b1, 1'b0);
    check_val("add_c3_aluop", {28'd0, alu_operation}, 32'h2);
    check_val("add_c3_alusrc", {31'd0, alusrc}, 32'd0);
    cyc(1'b1, 1'b0);
    check_val("add_c4_wb", {28'd0, regwrite, pc_we, pcsrc, memtoreg}, 32'hC);
    cyc(1'b1, 1'b0);
    check_val("add_c5_fetch", {29'd0, mem_req, ir_we, regwrite}, 32'h6);
    check_val("add_c5_aluclr", {28'd0, alu_operation}, 32'h0);

    // lw with three wait cycles in MEMRD
    do_reset();
    set_instr(7'b0000011, 3'b010, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    check_val("lw_exec_alu", {27'd0, alusrc, alu_operation}, 32'h12);
    mdr_pulses = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0);
      check_val($sformatf("lw_wait%0d", i), {29'd0, mem_req, iord, mem_we}, 32'h6);
      mdr_pulses += int'(mdr_we);
    end
    cyc(1'b1, 1'b0);
    check_val("lw_done_mdrwe", {30'd0, mem_req, mdr_we}, 32'h3);
    mdr_pulses += int'(mdr_we);
    cyc(1'b1, 1'b0);
    check_val("lw_wb", {29'd0, memtoreg, regwrite, pc_we}, 32'h7);
    mdr_pulses += int'(mdr_we);
    check_val("lw_mdr_pulses", mdr_pulses, 32'd1);
    cyc(1'b1, 1'b0);
    check_val("lw_refetch", {30'd0, mem_req, iord}, 32'h2);

    // sw, zero-wait
    do_reset();
    set_instr(7'b0100011, 3'b010, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    check_val("sw_memwr", {26'd0, mem_req, mem_we, iord, pc_we, pcsrc, regwrite}, 32'h3C);
    cyc(1'b1, 1'b0);
    check_val("sw_refetch", {29'd0, mem_req, mem_we, iord}, 32'h4);

    // beq taken, then not taken
    do_reset();
    set_instr(7'b1100011, 3'b000, 1'b0);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    check_val("beq_t_pc", {30'd0, pc_we, pcsrc}, 32'h3);
    check_val("beq_t_alu", {28'd0, alu_operation}, 32'h6);
    check_val("beq_t_rw", {31'd0, regwrite}, 32'd0);
    cyc(1'b1, 1'b0);
    check_val("beq_refetch", {30'd0, ir_we, pc_we}, 32'h2);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    check_val("beq_nt_pc", {29'd0, pc_we, pcsrc, regwrite}, 32'h4);

    // ALU decode table
    for (int i = 0; i < 15; i++) begin
      logic [14:0] v;
      logic exp_src;
      v = alu_vec[i];
      exp_src = (v[14:8] == 7'b0010011) || (v[14:8] == 7'b0100011);
      do_reset();
      set_instr(v[14:8], v[7:5], v[4]);
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      check_val($sformatf("alu_op_%0d", i), {28'd0, alu_operation}, {28'd0, v[3:0]});
      check_val($sformatf("alu_src_%0d", i), {31'd0, alusrc}, {31'd0, exp_src});
    end

    // Illegal opcode traps after DECODE; reset clears and restarts
    do_reset();
    set_instr(7'b1111111, 3'b000, 1'b0);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    check_val("trap_outs", {17'd0, outs_s}, 32'h1);
    cyc(1'b1, 1'b1);
    check_val("trap_held", {17'd0, outs_s}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_val("trap_async_clr", {31'd0, trap}, 32'd0);
    do_reset();
    set_instr(7'b0110011, 3'b000, 1'b0);
    cyc(1'b1, 1'b0);
    check_val("restart_fetch", {30'd0, mem_req, trap}, 32'h2);

`ifdef MEM_TIMEOUT_EN
    // Fetch never acknowledged: trap after 4 wait cycles
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0);
      check_val($sformatf("to_wait%0d", i), {30'd0, mem_req, trap}, 32'h2);
    end
    cyc(1'b0, 1'b0);
    check_val("to_trap", {30'd0, mem_req, trap}, 32'h1);
`else
    // Without the timeout the FSM keeps waiting
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0);
    end
    check_val("nowait_trap", {29'd0, mem_req, ir_we, trap}, 32'h4);
`endif

    // Reset in the middle of a pending request
    do_reset();
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    check_val("mid_req_before", {31'd0, mem_req}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_val("mid_req_async", {17'd0, outs_s}, 32'd0);
    @(negedge clk);
    #1;
    check_val("mid_req_held", {17'd0, outs_s}, 32'd0);
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
